// File: rtl/ei_tdp_ram_arbiter.sv
// Round-robin arbiter sharing both ports of a true dual-port RAM among NUM_REQ requesters.
// Optionally zero-fills the RAM after reset before any request is accepted.
module ei_tdp_ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int RD_LAT     = 1,
    parameter int INIT_EN    = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_rdata,
    output logic                             init_done,
    output logic                             we_a,
    output logic                             we_b,
    output logic                             re_a,
    output logic                             re_b,
    output logic [ADDR_WIDTH-1:0]            addr_a,
    output logic [ADDR_WIDTH-1:0]            addr_b,
    output logic [DATA_WIDTH-1:0]            data_a,
    output logic [DATA_WIDTH-1:0]            data_b,
    input  logic [DATA_WIDTH-1:0]            out_a,
    input  logic [DATA_WIDTH-1:0]            out_b
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] INIT_PAIRS = {1'b1, {(ADDR_WIDTH-1){1'b0}}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                     state_q;
    logic [IDW-1:0]             rrPtr_q, rrPtr_d;
    logic [ADDR_WIDTH-1:0]      initCnt_q;
    logic                       initDone_q;
    logic                       weA_q, weB_q, reA_q, reB_q;
    logic [ADDR_WIDTH-1:0]      addrA_q, addrB_q;
    logic [DATA_WIDTH-1:0]      dataA_q, dataB_q;
    logic [NUM_REQ-1:0]         rspValid_q;
    logic [NUM_REQ*DATA_WIDTH-1:0] rspRdata_q;
    logic [RD_LAT:0]            tagVldA_q, tagVldB_q;
    logic [RD_LAT:0][IDW-1:0]   tagIdA_q, tagIdB_q;

    logic                       grantA, grantB;
    logic [IDW-1:0]             idA, idB;
    logic [ADDR_WIDTH-1:0]      selAddrA;
    logic                       selWeA;
    logic [IDW:0]               scanSum;
    logic [IDW-1:0]             scanId;

    function automatic logic [IDW-1:0] nextId(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    // Scan from the round-robin pointer: first valid wins A, next compatible valid wins B.
    // B must not touch A's address unless both are reads, which keeps write/read hazards apart.
    always_comb begin
        grantA   = 1'b0;
        grantB   = 1'b0;
        idA      = '0;
        idB      = '0;
        selAddrA = '0;
        selWeA   = 1'b0;
        scanSum  = '0;
        scanId   = '0;
        if (state_q == ST_RUN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                scanSum = {1'b0, rrPtr_q} + (IDW+1)'(i);
                if (scanSum >= (IDW+1)'(NUM_REQ)) begin
                    scanSum = scanSum - (IDW+1)'(NUM_REQ);
                end
                scanId = scanSum[IDW-1:0];
                if (req_valid[scanId]) begin
                    if (!grantA) begin
                        grantA   = 1'b1;
                        idA      = scanId;
                        selAddrA = req_addr[scanId*ADDR_WIDTH +: ADDR_WIDTH];
                        selWeA   = req_we[scanId];
                    end else if (!grantB &&
                                 ((req_addr[scanId*ADDR_WIDTH +: ADDR_WIDTH] != selAddrA) ||
                                  (!selWeA && !req_we[scanId]))) begin
                        grantB = 1'b1;
                        idB    = scanId;
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grantA) begin
            req_ready[idA] = 1'b1;
        end
        if (grantB) begin
            req_ready[idB] = 1'b1;
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (grantB) begin
            rrPtr_d = nextId(idB);
        end else if (grantA) begin
            rrPtr_d = nextId(idA);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            rrPtr_q    <= '0;
            initCnt_q  <= '0;
            initDone_q <= 1'b0;
            weA_q      <= 1'b0;
            weB_q      <= 1'b0;
            reA_q      <= 1'b0;
            reB_q      <= 1'b0;
            addrA_q    <= '0;
            addrB_q    <= '0;
            dataA_q    <= '0;
            dataB_q    <= '0;
            rspValid_q <= '0;
            rspRdata_q <= '0;
            tagVldA_q  <= '0;
            tagVldB_q  <= '0;
            tagIdA_q   <= '0;
            tagIdB_q   <= '0;
        end else begin
            for (int s = 1; s <= RD_LAT; s++) begin
                tagVldA_q[s] <= tagVldA_q[s-1];
                tagVldB_q[s] <= tagVldB_q[s-1];
                tagIdA_q[s]  <= tagIdA_q[s-1];
                tagIdB_q[s]  <= tagIdB_q[s-1];
            end

            // The last tag stage lines up with the cycle in which the RAM read data is valid.
            rspValid_q <= '0;
            if (tagVldA_q[RD_LAT]) begin
                rspValid_q[tagIdA_q[RD_LAT]]                           <= 1'b1;
                rspRdata_q[tagIdA_q[RD_LAT]*DATA_WIDTH +: DATA_WIDTH]  <= out_a;
            end
            if (tagVldB_q[RD_LAT]) begin
                rspValid_q[tagIdB_q[RD_LAT]]                           <= 1'b1;
                rspRdata_q[tagIdB_q[RD_LAT]*DATA_WIDTH +: DATA_WIDTH]  <= out_b;
            end

            case (state_q)
                ST_INIT: begin
                    tagVldA_q[0] <= 1'b0;
                    tagVldB_q[0] <= 1'b0;
                    reA_q        <= 1'b0;
                    reB_q        <= 1'b0;
                    dataA_q      <= '0;
                    dataB_q      <= '0;
                    if (initCnt_q == INIT_PAIRS) begin
                        state_q    <= ST_RUN;
                        initDone_q <= 1'b1;
                        weA_q      <= 1'b0;
                        weB_q      <= 1'b0;
                        addrA_q    <= '0;
                        addrB_q    <= '0;
                    end else begin
                        weA_q     <= 1'b1;
                        weB_q     <= 1'b1;
                        addrA_q   <= {initCnt_q[ADDR_WIDTH-2:0], 1'b0};
                        addrB_q   <= {initCnt_q[ADDR_WIDTH-2:0], 1'b1};
                        initCnt_q <= initCnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    initDone_q   <= 1'b1;
                    rrPtr_q      <= rrPtr_d;
                    weA_q        <= grantA && req_we[idA];
                    reA_q        <= grantA && !req_we[idA];
                    addrA_q      <= grantA ? req_addr[idA*ADDR_WIDTH +: ADDR_WIDTH] : '0;
                    dataA_q      <= grantA ? req_wdata[idA*DATA_WIDTH +: DATA_WIDTH] : '0;
                    weB_q        <= grantB && req_we[idB];
                    reB_q        <= grantB && !req_we[idB];
                    addrB_q      <= grantB ? req_addr[idB*ADDR_WIDTH +: ADDR_WIDTH] : '0;
                    dataB_q      <= grantB ? req_wdata[idB*DATA_WIDTH +: DATA_WIDTH] : '0;
                    tagVldA_q[0] <= grantA && !req_we[idA];
                    tagVldB_q[0] <= grantB && !req_we[idB];
                    tagIdA_q[0]  <= idA;
                    tagIdB_q[0]  <= idB;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign init_done = initDone_q;
    assign we_a      = weA_q;
    assign we_b      = weB_q;
    assign re_a      = reA_q;
    assign re_b      = reB_q;
    assign addr_a    = addrA_q;
    assign addr_b    = addrB_q;
    assign data_a    = dataA_q;
    assign data_b    = dataB_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_ei_tdp_ram_arbiter.sv
// Directed testbench for ei_tdp_ram_arbiter with a behavioural one-cycle-latency TDP RAM.
module tb_ei_tdp_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  reqValid, reqWe, reqReady, rspValid;
    logic [39:0] reqAddr;
    logic [31:0] reqWdata, rspRdata;
    logic        initDone, weA, weB, reA, reB;
    logic [9:0]  addrA, addrB;
    logic [7:0]  dataA, dataB, outA, outB;
    logic [7:0]  mem [0:1023];

    int testsRun    = 0;
    int testsFailed = 0;

    ei_tdp_ram_arbiter #(
        .ADDR_WIDTH(10), .DATA_WIDTH(8), .NUM_REQ(4), .RD_LAT(1), .INIT_EN(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
        .req_ready(reqReady), .rsp_valid(rspValid), .rsp_rdata(rspRdata),
        .init_done(initDone),
        .we_a(weA), .we_b(weB), .re_a(reA), .re_b(reB),
        .addr_a(addrA), .addr_b(addrB), .data_a(dataA), .data_b(dataB),
        .out_a(outA), .out_b(outB)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, data valid the cycle after the read is on the pins.
    always @(posedge clk) begin
        if (weA) mem[addrA] <= dataA;
        if (weB) mem[addrB] <= dataB;
        if (reA) outA <= mem[addrA];
        if (reB) outB <= mem[addrB];
    end

    task automatic setReq(input logic [1:0] id, input logic we, input logic [9:0] addr,
                          input logic [7:0] data);
        reqValid[id]          = 1'b1;
        reqWe[id]             = we;
        reqAddr[id*10 +: 10]  = addr;
        reqWdata[id*8 +: 8]   = data;
    endtask

    task automatic test_reset;
        logic [86:0] allOut;
        reset    = 1'b1;
        reqValid = 4'hF;
        reqWe    = 4'h0;
        reqAddr  = '0;
        reqWdata = '0;
        repeat (2) @(negedge clk);
        allOut = {reqReady, rspValid, rspRdata, initDone, weA, weB, reA, reB,
                  addrA, addrB, dataA, dataB};
        testsRun++;
        if (allOut !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", allOut);
        end
    endtask

    task automatic test_init;
        logic [40:0] obs, exp;
        reset = 1'b0;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            obs = {weA, weB, reA, reB, addrA, addrB, dataA, dataB, initDone, reqReady};
            exp = {1'b1, 1'b1, 1'b0, 1'b0, 10'(2*k), 10'(2*k+1), 8'h00, 8'h00, 1'b0, 4'h0};
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL init_pair_%0d: got %h, expected %h", k, obs, exp);
            end
        end
        reqValid = 4'h0;
        @(negedge clk);
        testsRun++;
        if ({initDone, weA, weB} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL init_done: got %b, expected 100", {initDone, weA, weB});
        end
    endtask

    task automatic test_write_setup;
        for (int i = 0; i < 4; i++) setReq(2'(i), 1'b1, 10'h100 + 10'(i), 8'h10 + 8'(i));
        #1;
        testsRun++;
        if (reqReady !== 4'b0011) begin
            testsFailed++;
            $display("[TB] FAIL wr4_ready1: got %b, expected 0011", reqReady);
        end
        @(negedge clk);
        reqValid[1:0] = 2'b00;
        #1;
        testsRun++;
        if ({reqReady, weA, reA, addrA, dataA, weB, reB, addrB, dataB} !==
            {4'b1100, 2'b10, 10'h100, 8'h10, 2'b10, 10'h101, 8'h11}) begin
            testsFailed++;
            $display("[TB] FAIL wr4_cycle1: ready %b addrA %h dataA %h addrB %h dataB %h",
                     reqReady, addrA, dataA, addrB, dataB);
        end
        @(negedge clk);
        reqValid = 4'h0;
        testsRun++;
        if ({weA, addrA, dataA, weB, addrB, dataB} !==
            {1'b1, 10'h102, 8'h12, 1'b1, 10'h103, 8'h13}) begin
            testsFailed++;
            $display("[TB] FAIL wr4_cycle2: addrA %h dataA %h addrB %h dataB %h",
                     addrA, dataA, addrB, dataB);
        end
        repeat (3) begin
            @(negedge clk);
            testsRun++;
            if (rspValid !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL wr_no_rsp: got %b, expected 0000", rspValid);
            end
        end
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < 4; i++) setReq(2'(i), 1'b0, 10'h100 + 10'(i), 8'h00);
        #1;
        testsRun++;
        if (reqReady !== 4'b0011) begin
            testsFailed++;
            $display("[TB] FAIL rr_ready1: got %b, expected 0011", reqReady);
        end
        @(negedge clk);
        reqValid = 4'b1100;
        #1;
        testsRun++;
        if ({reqReady, reA, addrA, reB, addrB} !== {4'b1100, 1'b1, 10'h100, 1'b1, 10'h101}) begin
            testsFailed++;
            $display("[TB] FAIL rr_cycle1: ready %b addrA %h addrB %h", reqReady, addrA, addrB);
        end
        @(negedge clk);
        reqValid = 4'h0;
        testsRun++;
        if ({reA, addrA, reB, addrB, rspValid} !== {1'b1, 10'h102, 1'b1, 10'h103, 4'b0000}) begin
            testsFailed++;
            $display("[TB] FAIL rr_cycle2: addrA %h addrB %h rsp %b", addrA, addrB, rspValid);
        end
        @(negedge clk);
        testsRun++;
        if ({rspValid, rspRdata[15:0]} !== {4'b0011, 8'h11, 8'h10}) begin
            testsFailed++;
            $display("[TB] FAIL rr_rsp01: got %b/%h, expected 0011/1110", rspValid, rspRdata[15:0]);
        end
        @(negedge clk);
        testsRun++;
        if ({rspValid, rspRdata[31:16]} !== {4'b1100, 8'h13, 8'h12}) begin
            testsFailed++;
            $display("[TB] FAIL rr_rsp23: got %b/%h, expected 1100/1312", rspValid, rspRdata[31:16]);
        end
        @(negedge clk);
        reqValid = 4'hF;
        #1;
        testsRun++;
        if ({rspValid, reqReady} !== {4'b0000, 4'b0011}) begin
            testsFailed++;
            $display("[TB] FAIL rr_ptr_wrap: rsp %b ready %b, expected 0000 0011", rspValid, reqReady);
        end
        reqValid = 4'h0;
    endtask

    task automatic test_write_read;
        @(negedge clk);
        setReq(2'd0, 1'b1, 10'h005, 8'hA5);
        #1;
        testsRun++;
        if (reqReady !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL wrrd_ready_wr: got %b, expected 0001", reqReady);
        end
        @(negedge clk);
        setReq(2'd0, 1'b0, 10'h005, 8'h00);
        #1;
        testsRun++;
        if ({reqReady, weA, addrA, dataA, weB} !== {4'b0001, 1'b1, 10'h005, 8'hA5, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL wrrd_write_pins: ready %b weA %b addrA %h dataA %h",
                     reqReady, weA, addrA, dataA);
        end
        @(negedge clk);
        reqValid = 4'h0;
        @(negedge clk);
        testsRun++;
        if (rspValid !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL wrrd_early_rsp: got %b, expected 0000", rspValid);
        end
        @(negedge clk);
        testsRun++;
        if ({rspValid, rspRdata[7:0]} !== {4'b0001, 8'hA5}) begin
            testsFailed++;
            $display("[TB] FAIL wrrd_rsp: got %b/%h, expected 0001/a5", rspValid, rspRdata[7:0]);
        end
    endtask

    task automatic test_last_addr;
        setReq(2'd3, 1'b0, 10'h3FF, 8'h00);
        #1;
        testsRun++;
        if (reqReady !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL last_ready: got %b, expected 1000", reqReady);
        end
        @(negedge clk);
        reqValid = 4'h0;
        repeat (2) @(negedge clk);
        testsRun++;
        if ({rspValid, rspRdata[31:24]} !== {4'b1000, 8'h00}) begin
            testsFailed++;
            $display("[TB] FAIL last_addr_cleared: got %b/%h, expected 1000/00",
                     rspValid, rspRdata[31:24]);
        end
    endtask

    task automatic test_hazard;
        @(negedge clk);
        setReq(2'd0, 1'b1, 10'h010, 8'h3C);
        setReq(2'd1, 1'b0, 10'h010, 8'h00);
        #1;
        testsRun++;
        if (reqReady !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL hazard_ready1: got %b, expected 0001", reqReady);
        end
        @(negedge clk);
        reqValid[0] = 1'b0;
        #1;
        testsRun++;
        if ({reqReady, weA, addrA, dataA, weB, reB} !== {4'b0010, 1'b1, 10'h010, 8'h3C, 2'b00}) begin
            testsFailed++;
            $display("[TB] FAIL hazard_cycle1: ready %b weA %b addrA %h dataA %h weB %b reB %b",
                     reqReady, weA, addrA, dataA, weB, reB);
        end
        @(negedge clk);
        reqValid = 4'h0;
        repeat (2) @(negedge clk);
        testsRun++;
        if ({rspValid, rspRdata[15:8]} !== {4'b0010, 8'h3C}) begin
            testsFailed++;
            $display("[TB] FAIL hazard_rsp: got %b/%h, expected 0010/3c", rspValid, rspRdata[15:8]);
        end
    endtask

    task automatic test_read_pair;
        @(negedge clk);
        setReq(2'd1, 1'b1, 10'h020, 8'h5A);
        @(negedge clk);
        reqValid = 4'h0;
        setReq(2'd2, 1'b0, 10'h020, 8'h00);
        setReq(2'd3, 1'b0, 10'h020, 8'h00);
        #1;
        testsRun++;
        if (reqReady !== 4'b1100) begin
            testsFailed++;
            $display("[TB] FAIL pair_ready: got %b, expected 1100", reqReady);
        end
        @(negedge clk);
        reqValid = 4'h0;
        testsRun++;
        if ({reA, addrA, reB, addrB} !== {1'b1, 10'h020, 1'b1, 10'h020}) begin
            testsFailed++;
            $display("[TB] FAIL pair_pins: reA %b addrA %h reB %b addrB %h", reA, addrA, reB, addrB);
        end
        repeat (2) @(negedge clk);
        testsRun++;
        if ({rspValid, rspRdata[31:16]} !== {4'b1100, 8'h5A, 8'h5A}) begin
            testsFailed++;
            $display("[TB] FAIL pair_rsp: got %b/%h, expected 1100/5a5a", rspValid, rspRdata[31:16]);
        end
        // Read on A blocks a later write to the same address; a third requester takes B.
        setReq(2'd0, 1'b0, 10'h030, 8'h00);
        setReq(2'd1, 1'b1, 10'h030, 8'h77);
        setReq(2'd2, 1'b0, 10'h031, 8'h00);
        #1;
        testsRun++;
        if (reqReady !== 4'b0101) begin
            testsFailed++;
            $display("[TB] FAIL read_blocks_write: got %b, expected 0101", reqReady);
        end
        reqValid = 4'h0;
    endtask

    task automatic test_reset_mid;
        logic [86:0] allOut;
        @(negedge clk);
        setReq(2'd0, 1'b0, 10'h005, 8'h00);
        @(negedge clk);
        reqValid = 4'h0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        allOut = {reqReady, rspValid, rspRdata, initDone, weA, weB, reA, reB,
                  addrA, addrB, dataA, dataB};
        testsRun++;
        if (allOut !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_outputs: got %h, expected 0", allOut);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            testsRun++;
            if ({rspValid, initDone, weA, addrA} !== {4'b0000, 1'b0, 1'b1, 10'(2*k)}) begin
                testsFailed++;
                $display("[TB] FAIL midreset_reinit_%0d: rsp %b done %b weA %b addrA %h",
                         k, rspValid, initDone, weA, addrA);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
        outA = 8'h00;
        outB = 8'h00;
        test_reset;
        test_init;
        test_write_setup;
        test_round_robin;
        test_write_read;
        test_last_addr;
        test_hazard;
        test_read_pair;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
